axi_mm_fifo_s2mm: RTL

Write side of the memory-backed AXI FIFO. Packs an AXI-Stream into fixed-size blocks of C_WIDTH beats and writes each block to a circular region of DDR with one AXI write burst. Beat 0 of each block holds the valid flags, beat 1 holds the last flags, and beats 2..C_WIDTH-1 hold data slots. This is the layout that axi_mm_fifo_mm2s reads back and replays downstream.

---
 rtl/axi_mm_fifo_s2mm.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/axi_mm_fifo_s2mm.sv
// axi_mm_fifo_s2mm: packs an AXI-Stream into C_WIDTH-beat blocks (valid flags, last flags, data slots) burst-written to a DDR ring.
// Define AXI_MM_FIFO_S2MM_FLUSH_ON_TLAST_EN to close a block right after an accepted tlast beat.
module axi_mm_fifo_s2mm #(
  parameter int C_WIDTH      = 64,
  parameter int C_START_ADDR = 0,
  parameter int C_END_ADDR   = 134217727,
  parameter int C_TIMEOUT    = 256,
  localparam int AW          = $clog2(C_END_ADDR + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  output logic               busy,
  output logic [AW-1:0]      mem_ptr,
  input  logic [AW-1:0]      rd_ptr,
  output logic               wr_error,
  output logic [AW-1:0]      m_axi_awaddr,
  output logic [7:0]         m_axi_awlen,
  output logic               m_axi_awvalid,
  input  logic               m_axi_awready,
  output logic [C_WIDTH-1:0] m_axi_wdata,
  output logic               m_axi_wlast,
  output logic               m_axi_wvalid,
  input  logic               m_axi_wready,
  input  logic [1:0]         m_axi_bresp,
  input  logic               m_axi_bvalid,
  output logic               m_axi_bready,
  input  logic [C_WIDTH-1:0] s_axis_tdata,
  input  logic               s_axis_tlast,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready
);
  localparam int NS = C_WIDTH - 2;
  localparam int CW = $clog2(C_WIDTH);
  localparam int BSH = $clog2(C_WIDTH * (C_WIDTH / 8));
  localparam logic [AW-1:0] START_A = AW'(C_START_ADDR);
  localparam logic [AW-1:0] END_A = AW'(C_END_ADDR);
  localparam logic [AW-1:0] BLK_A = AW'(C_WIDTH * (C_WIDTH / 8));
  localparam logic [CW-1:0] SLOTS = CW'(NS);
  localparam logic [CW-1:0] LAST_BEAT = CW'(C_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_FILL, ST_WAIT_SPACE, ST_SET_ADDR,
    ST_WRITE_TVALID, ST_WRITE_TLAST, ST_WRITE_TDATA, ST_WAIT_RESP
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, widx_q, widx_d, sidx;
  logic [31:0] tmo_q, tmo_d;
  logic [NS-1:0] fv_q, fv_d, fl_q, fl_d;
  logic [AW-1:0] mem_ptr_q, mem_ptr_d, awaddr_q, awaddr_d, next_ptr;
  logic [7:0] awlen_q, awlen_d;
  logic awvalid_q, awvalid_d, wr_error_q, wr_error_d;
  logic accept, tlast_close, tmo_close;
  logic [C_WIDTH-1:0] slot_q [NS];

`ifdef AXI_MM_FIFO_S2MM_FLUSH_ON_TLAST_EN
  assign tlast_close = accept && s_axis_tlast;
`else
  assign tlast_close = 1'b0;
`endif

  assign s_axis_tready = state_q == ST_FILL && cnt_q < SLOTS;
  assign accept = s_axis_tready && s_axis_tvalid;
  assign tmo_close = C_TIMEOUT != 0 && !accept && cnt_q != '0 && tmo_q == 32'(C_TIMEOUT - 1);
  assign next_ptr = mem_ptr_q[AW-1:BSH] == END_A[AW-1:BSH] ? START_A : mem_ptr_q + BLK_A;
  assign sidx = widx_q - CW'(2);
  assign busy = state_q != ST_IDLE;
  assign mem_ptr = mem_ptr_q;
  assign wr_error = wr_error_q;
  assign m_axi_awaddr = awaddr_q;
  assign m_axi_awlen = awlen_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_bready = state_q == ST_WAIT_RESP;
  assign m_axi_wvalid = state_q inside {ST_WRITE_TVALID, ST_WRITE_TLAST, ST_WRITE_TDATA};
  assign m_axi_wlast = state_q == ST_WRITE_TDATA && widx_q == LAST_BEAT;
  // Slots never filled in this block read as zero regardless of stale buffer contents.
  assign m_axi_wdata = state_q == ST_WRITE_TVALID ? {2'b00, fv_q} :
                       state_q == ST_WRITE_TLAST  ? {2'b00, fl_q} :
                       state_q == ST_WRITE_TDATA && fv_q[sidx] ? slot_q[sidx] : '0;

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    widx_d = widx_q;
    tmo_d = tmo_q;
    fv_d = fv_q;
    fl_d = fl_q;
    mem_ptr_d = mem_ptr_q;
    awaddr_d = awaddr_q;
    awlen_d = awlen_q;
    awvalid_d = awvalid_q;
    wr_error_d = wr_error_q;
    if (accept) begin
      fv_d[cnt_q] = 1'b1;
      fl_d[cnt_q] = s_axis_tlast;
      cnt_d = cnt_q + CW'(1);
    end
    case (state_q)
      ST_IDLE: state_d = enable ? ST_FILL : ST_IDLE;
      ST_FILL: begin
        tmo_d = accept ? '0 : cnt_q != '0 ? tmo_q + 32'd1 : tmo_q;
        if (cnt_q == SLOTS || (!enable && cnt_d != '0) || tlast_close || tmo_close) begin
          state_d = ST_WAIT_SPACE;
          tmo_d = '0;
        end else if (!enable) state_d = ST_IDLE;
      end
      // One block always stays empty so a full ring is distinguishable from an empty one.
      ST_WAIT_SPACE: if (next_ptr != rd_ptr) begin
        state_d = ST_SET_ADDR;
        awvalid_d = 1'b1;
        awaddr_d = mem_ptr_q;
        awlen_d = 8'(C_WIDTH - 1);
      end
      ST_SET_ADDR: if (m_axi_awready) begin
        awvalid_d = 1'b0;
        state_d = ST_WRITE_TVALID;
      end
      ST_WRITE_TVALID: state_d = m_axi_wready ? ST_WRITE_TLAST : ST_WRITE_TVALID;
      ST_WRITE_TLAST: if (m_axi_wready) begin
        state_d = ST_WRITE_TDATA;
        widx_d = CW'(2);
      end
      ST_WRITE_TDATA: if (m_axi_wready) begin
        widx_d = widx_q + CW'(1);
        state_d = m_axi_wlast ? ST_WAIT_RESP : ST_WRITE_TDATA;
      end
      ST_WAIT_RESP: if (m_axi_bvalid) begin
        wr_error_d = wr_error_q | (m_axi_bresp != 2'b00);
        mem_ptr_d = next_ptr;
        fv_d = '0;
        fl_d = '0;
        cnt_d = '0;
        tmo_d = '0;
        state_d = enable ? ST_FILL : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      widx_q <= '0;
      tmo_q <= '0;
      fv_q <= '0;
      fl_q <= '0;
      mem_ptr_q <= START_A;
      awaddr_q <= '0;
      awlen_q <= '0;
      awvalid_q <= 1'b0;
      wr_error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      widx_q <= widx_d;
      tmo_q <= tmo_d;
      fv_q <= fv_d;
      fl_q <= fl_d;
      mem_ptr_q <= mem_ptr_d;
      awaddr_q <= awaddr_d;
      awlen_q <= awlen_d;
      awvalid_q <= awvalid_d;
      wr_error_q <= wr_error_d;
    end

  always_ff @(posedge clk)
    if (accept) slot_q[cnt_q] <= s_axis_tdata;
endmodule
